// File: rtl/mips_pkg.sv
// Shared MIPS pipeline encodings: writeback source select and load type codes.
// Every stage that decodes or consumes these fields imports them from here.
package mips_pkg;

    localparam int XLEN = 32;
    localparam int REGW = 5;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;
    localparam logic [1:0] WB_RSVD = 2'd3;

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LH  = 3'd1;
    localparam logic [2:0] LD_LHU = 3'd2;
    localparam logic [2:0] LD_LB  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;

    function automatic logic ld_type_reserved(input logic [2:0] t);
        return t > LD_LBU;
    endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Load extraction and alignment check: picks the byte/halfword out of the raw
// memory word, extends it, and flags misaligned or reserved load types.
module load_align
    import mips_pkg::*;
(
    input  logic [2:0]      load_type_i,
    input  logic [1:0]      offset_i,
    input  logic [XLEN-1:0] word_i,
    output logic [XLEN-1:0] data_o,
    output logic            misalign_o,
    output logic            reserved_o
);

    logic [15:0] half;
    logic [7:0]  byte_sel;

    always_comb begin
        half = offset_i[1] ? word_i[31:16] : word_i[15:0];
        case (offset_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
    end

    always_comb begin
        data_o     = '0;
        misalign_o = 1'b0;
        reserved_o = ld_type_reserved(load_type_i);
        case (load_type_i)
            LD_LW: begin
                data_o     = word_i;
                misalign_o = (offset_i != 2'd0);
            end
            LD_LH: begin
                data_o     = {{16{half[15]}}, half};
                misalign_o = offset_i[0];
            end
            LD_LHU: begin
                data_o     = {16'h0000, half};
                misalign_o = offset_i[0];
            end
            LD_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  data_o = {24'h000000, byte_sel};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures the fully selected and extended writeback
// value so the regfile write and forwarding paths come straight from flops.
module mem_wb_stage
    import mips_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            mem_valid,
    input  logic            mem_RegWrite,
    input  logic [REGW-1:0] mem_WriteAddr,
    input  logic [1:0]      mem_WbSel,
    input  logic [2:0]      mem_LoadType,
    input  logic [XLEN-1:0] mem_AluResult,
    input  logic [XLEN-1:0] mem_LoadData,
    input  logic [XLEN-1:0] mem_PcPlus8,
    input  logic            stall,
    input  logic            flush,
    output logic            RegWrite,
    output logic [REGW-1:0] WriteAddr,
    output logic [XLEN-1:0] WriteData,
    output logic            wb_valid,
    output logic            wb_misalign,
    output logic [XLEN-1:0] instret
);

    logic [XLEN-1:0] ld_data;
    logic            ld_misalign;
    logic            ld_reserved;

    logic            regwrite_d, regwrite_q;
    logic [XLEN-1:0] data_d, data_q;
    logic            misalign_d, misalign_q;
    logic [REGW-1:0] addr_q;
    logic            valid_q;
    logic [XLEN-1:0] instret_q;
    logic            is_load;
    logic            reserved;

    load_align u_load_align (
        .load_type_i (mem_LoadType),
        .offset_i    (mem_AluResult[1:0]),
        .word_i      (mem_LoadData),
        .data_o      (ld_data),
        .misalign_o  (ld_misalign),
        .reserved_o  (ld_reserved)
    );

    // A reserved code in either select field suppresses the write and zeroes the data.
    always_comb begin
        is_load  = (mem_WbSel == WB_LOAD);
        reserved = (mem_WbSel == WB_RSVD) || ld_reserved;

        case (mem_WbSel)
            WB_ALU:  data_d = mem_AluResult;
            WB_LOAD: data_d = ld_data;
            WB_LINK: data_d = mem_PcPlus8;
            default: data_d = '0;
        endcase
        if (reserved) begin
            data_d = '0;
        end

        misalign_d = mem_valid && is_load && ld_misalign;
        regwrite_d = mem_valid && mem_RegWrite && (mem_WriteAddr != '0)
                     && !misalign_d && !reserved;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            regwrite_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            instret_q  <= '0;
        end else if (flush) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            misalign_q <= 1'b0;
        end else if (stall) begin
            misalign_q <= 1'b0;
        end else begin
            regwrite_q <= regwrite_d;
            addr_q     <= mem_WriteAddr;
            data_q     <= data_d;
            valid_q    <= mem_valid;
            misalign_q <= misalign_d;
            if (mem_valid) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    assign RegWrite    = regwrite_q;
    assign WriteAddr   = addr_q;
    assign WriteData   = data_q;
    assign wb_valid    = valid_q;
    assign wb_misalign = misalign_q;
    assign instret     = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, hand-written
// stall/flush/wrap/reset sequences, and randomized traffic against a reference model.
module tb_mem_wb_stage;

    typedef struct {
        logic        valid;
        logic        rw;
        logic [4:0]  addr;
        logic [1:0]  wbsel;
        logic [2:0]  lt;
        logic [31:0] alu;
        logic [31:0] ld;
        logic [31:0] pc8;
    } in_t;

    typedef struct {
        logic        rw;
        logic [31:0] data;
        logic        valid;
        logic        mis;
    } exp_t;

    typedef struct {
        in_t         in;
        logic        exp_rw;
        logic [31:0] exp_data;
        logic        exp_mis;
        logic        chk_d;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        mem_valid;
    logic        mem_RegWrite;
    logic [4:0]  mem_WriteAddr;
    logic [1:0]  mem_WbSel;
    logic [2:0]  mem_LoadType;
    logic [31:0] mem_AluResult;
    logic [31:0] mem_LoadData;
    logic [31:0] mem_PcPlus8;
    logic        stall;
    logic        flush;
    logic        RegWrite;
    logic [4:0]  WriteAddr;
    logic [31:0] WriteData;
    logic        wb_valid;
    logic        wb_misalign;
    logic [31:0] instret;

    int checks;
    int failures;

    mem_wb_stage dut (
        .clock         (clk),
        .reset         (rst_n),
        .mem_valid     (mem_valid),
        .mem_RegWrite  (mem_RegWrite),
        .mem_WriteAddr (mem_WriteAddr),
        .mem_WbSel     (mem_WbSel),
        .mem_LoadType  (mem_LoadType),
        .mem_AluResult (mem_AluResult),
        .mem_LoadData  (mem_LoadData),
        .mem_PcPlus8   (mem_PcPlus8),
        .stall         (stall),
        .flush         (flush),
        .RegWrite      (RegWrite),
        .WriteAddr     (WriteAddr),
        .WriteData     (WriteData),
        .wb_valid      (wb_valid),
        .wb_misalign   (wb_misalign),
        .instret       (instret)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b expected=%0b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h expected=%08h", nm, act, exp);
        end
    endtask

    // Reference: extraction done with shifts, masks and magnitude tests on whole words.
    function automatic exp_t ref_cap(input in_t i);
        exp_t        e;
        logic [31:0] off;
        logic [31:0] v;
        logic        bad;
        logic        mis;
        off = {30'd0, i.alu[1:0]};
        v   = 32'd0;
        bad = 1'b0;
        mis = 1'b0;
        case (i.wbsel)
            2'd0: v = i.alu;
            2'd2: v = i.pc8;
            2'd1: begin
                case (i.lt)
                    3'd0: begin
                        v   = i.ld;
                        mis = (off != 32'd0);
                    end
                    3'd1, 3'd2: begin
                        v = ((off >= 32'd2) ? (i.ld >> 16) : i.ld) & 32'h0000FFFF;
                        if (i.lt == 3'd1 && v >= 32'h00008000) v = v | 32'hFFFF0000;
                        mis = ((off % 32'd2) == 32'd1);
                    end
                    3'd3, 3'd4: begin
                        v = (i.ld >> (off * 32'd8)) & 32'h000000FF;
                        if (i.lt == 3'd3 && v >= 32'h00000080) v = v | 32'hFFFFFF00;
                    end
                    default: bad = 1'b1;
                endcase
            end
            default: bad = 1'b1;
        endcase
        if (i.lt > 3'd4) bad = 1'b1;
        mis     = mis && i.valid;
        e.data  = bad ? 32'd0 : v;
        e.mis   = mis;
        e.valid = i.valid;
        e.rw    = i.valid && i.rw && (i.addr != 5'd0) && !mis && !bad;
        return e;
    endfunction

    function automatic in_t mk_in(input logic valid, input logic rw, input logic [4:0] addr,
                                  input logic [1:0] wbsel, input logic [2:0] lt,
                                  input logic [31:0] alu, input logic [31:0] ld);
        in_t i;
        i.valid = valid;
        i.rw    = rw;
        i.addr  = addr;
        i.wbsel = wbsel;
        i.lt    = lt;
        i.alu   = alu;
        i.ld    = ld;
        i.pc8   = 32'h0040_0010;
        return i;
    endfunction

    function automatic vec_t mk(input in_t i, input logic rw, input logic [31:0] d,
                                input logic mis, input logic chkd);
        vec_t v;
        v.in       = i;
        v.exp_rw   = rw;
        v.exp_data = d;
        v.exp_mis  = mis;
        v.chk_d    = chkd;
        return v;
    endfunction

    task automatic drive(input in_t i);
        mem_valid     = i.valid;
        mem_RegWrite  = i.rw;
        mem_WriteAddr = i.addr;
        mem_WbSel     = i.wbsel;
        mem_LoadType  = i.lt;
        mem_AluResult = i.alu;
        mem_LoadData  = i.ld;
        mem_PcPlus8   = i.pc8;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drive(mk_in(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    localparam int NVEC = 18;
    vec_t        tbl[NVEC];
    in_t         rin;
    exp_t        m;
    exp_t        c;
    logic [4:0]  m_addr;
    logic [31:0] m_ir;
    logic [31:0] ic;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        drive(mk_in(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0));

        #2;
        chk1 ("rst.rw",      RegWrite,    1'b0);
        chk32("rst.data",    WriteData,   32'd0);
        chk1 ("rst.valid",   wb_valid,    1'b0);
        chk1 ("rst.mis",     wb_misalign, 1'b0);
        chk32("rst.instret", instret,     32'd0);
        chk32("rst.addr",    {27'd0, WriteAddr}, 32'd0);

        tbl[0]  = mk(mk_in(1, 1, 5'd5, 2'd1, 3'd3, 32'h1000_0000, 32'h80FF7F01), 1, 32'h00000001, 0, 1);
        tbl[1]  = mk(mk_in(1, 1, 5'd5, 2'd1, 3'd3, 32'h1000_0001, 32'h80FF7F01), 1, 32'h0000007F, 0, 1);
        tbl[2]  = mk(mk_in(1, 1, 5'd5, 2'd1, 3'd3, 32'h1000_0002, 32'h80FF7F01), 1, 32'hFFFFFFFF, 0, 1);
        tbl[3]  = mk(mk_in(1, 1, 5'd5, 2'd1, 3'd3, 32'h1000_0003, 32'h80FF7F01), 1, 32'hFFFFFF80, 0, 1);
        tbl[4]  = mk(mk_in(1, 1, 5'd6, 2'd1, 3'd4, 32'h1000_0001, 32'h80FF7F01), 1, 32'h0000007F, 0, 1);
        tbl[5]  = mk(mk_in(1, 1, 5'd6, 2'd1, 3'd4, 32'h1000_0002, 32'h80FF7F01), 1, 32'h000000FF, 0, 1);
        tbl[6]  = mk(mk_in(1, 1, 5'd7, 2'd1, 3'd1, 32'h1000_0000, 32'h80017FFF), 1, 32'h00007FFF, 0, 1);
        tbl[7]  = mk(mk_in(1, 1, 5'd7, 2'd1, 3'd1, 32'h1000_0002, 32'h80017FFF), 1, 32'hFFFF8001, 0, 1);
        tbl[8]  = mk(mk_in(1, 1, 5'd7, 2'd1, 3'd2, 32'h1000_0002, 32'h80017FFF), 1, 32'h00008001, 0, 1);
        tbl[9]  = mk(mk_in(1, 1, 5'd7, 2'd1, 3'd1, 32'h1000_0001, 32'h80017FFF), 0, 32'd0,        1, 0);
        tbl[10] = mk(mk_in(1, 1, 5'd0, 2'd0, 3'd0, 32'h12345678, 32'hDEADBEEF), 0, 32'h12345678, 0, 1);
        tbl[11] = mk(mk_in(1, 1, 5'd5, 2'd0, 3'd0, 32'h12345678, 32'hDEADBEEF), 1, 32'h12345678, 0, 1);
        tbl[12] = mk(mk_in(1, 1, 5'd31, 2'd2, 3'd0, 32'h00000003, 32'hDEADBEEF), 1, 32'h00400010, 0, 1);
        tbl[13] = mk(mk_in(1, 1, 5'd9, 2'd3, 3'd0, 32'h12345678, 32'hDEADBEEF), 0, 32'd0,        0, 1);
        tbl[14] = mk(mk_in(1, 1, 5'd9, 2'd1, 3'd5, 32'h1000_0000, 32'hDEADBEEF), 0, 32'd0,        0, 1);
        tbl[15] = mk(mk_in(0, 1, 5'd9, 2'd0, 3'd0, 32'h11112222, 32'hDEADBEEF), 0, 32'd0,        0, 0);
        tbl[16] = mk(mk_in(1, 1, 5'd3, 2'd1, 3'd0, 32'h1000_0000, 32'hCAFEF00D), 1, 32'hCAFEF00D, 0, 1);
        tbl[17] = mk(mk_in(1, 1, 5'd3, 2'd1, 3'd0, 32'h1000_0002, 32'hCAFEF00D), 0, 32'd0,        1, 0);

        @(negedge clk);
        rst_n = 1'b1;
        ic = 32'd0;
        for (int k = 0; k < NVEC; k++) begin
            @(negedge clk);
            drive(tbl[k].in);
            @(posedge clk);
            #1;
            if (tbl[k].in.valid) ic = ic + 32'd1;
            chk1 ($sformatf("vec%0d.rw", k),      RegWrite,    tbl[k].exp_rw);
            chk1 ($sformatf("vec%0d.valid", k),   wb_valid,    tbl[k].in.valid);
            chk1 ($sformatf("vec%0d.mis", k),     wb_misalign, tbl[k].exp_mis);
            chk32($sformatf("vec%0d.addr", k),    {27'd0, WriteAddr}, {27'd0, tbl[k].in.addr});
            chk32($sformatf("vec%0d.instret", k), instret,     ic);
            if (tbl[k].chk_d) chk32($sformatf("vec%0d.data", k), WriteData, tbl[k].exp_data);
        end

        // Stall holds a completed ALU writeback for three cycles.
        @(negedge clk);
        drive(mk_in(1, 1, 5'd5, 2'd0, 3'd0, 32'h12345678, 32'd0));
        @(posedge clk);
        #1;
        ic = ic + 32'd1;
        chk1 ("alu5.rw", RegWrite, 1'b1);
        chk32("alu5.instret", instret, ic);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            stall = 1'b1;
            drive(mk_in(1, 1, 5'd9, 2'd2, 3'd0, $urandom, $urandom));
            @(posedge clk);
            #1;
            chk1 ($sformatf("stall%0d.rw", k),      RegWrite,  1'b1);
            chk1 ($sformatf("stall%0d.valid", k),   wb_valid,  1'b1);
            chk32($sformatf("stall%0d.data", k),    WriteData, 32'h12345678);
            chk32($sformatf("stall%0d.addr", k),    {27'd0, WriteAddr}, 32'd5);
            chk32($sformatf("stall%0d.instret", k), instret,   ic);
        end

        // Misalign pulse drops during a stall while the instruction stays valid.
        @(negedge clk);
        stall = 1'b0;
        drive(mk_in(1, 1, 5'd7, 2'd1, 3'd1, 32'h1000_0001, 32'h80017FFF));
        @(posedge clk);
        #1;
        ic = ic + 32'd1;
        chk1("mis.pulse", wb_misalign, 1'b1);
        @(negedge clk);
        stall = 1'b1;
        @(posedge clk);
        #1;
        chk1 ("mis_stall.mis",     wb_misalign, 1'b0);
        chk1 ("mis_stall.valid",   wb_valid,    1'b1);
        chk1 ("mis_stall.rw",      RegWrite,    1'b0);
        chk32("mis_stall.instret", instret,     ic);

        @(negedge clk);
        stall = 1'b1;
        flush = 1'b1;
        drive(mk_in(1, 1, 5'd5, 2'd0, 3'd0, 32'h0BADF00D, 32'd0));
        @(posedge clk);
        #1;
        chk1 ("stflush.valid",   wb_valid, 1'b0);
        chk1 ("stflush.rw",      RegWrite, 1'b0);
        chk32("stflush.instret", instret,  ic);
        @(negedge clk);
        stall = 1'b0;
        @(posedge clk);
        #1;
        chk1 ("flush.valid",   wb_valid, 1'b0);
        chk32("flush.instret", instret,  ic);
        flush = 1'b0;

        // Randomized traffic against the reference model.
        do_reset();
        m.rw = 1'b0; m.data = 32'd0; m.valid = 1'b0; m.mis = 1'b0;
        m_addr = 5'd0;
        m_ir   = 32'd0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rin.valid = ($urandom_range(0, 3) != 0);
            rin.rw    = ($urandom_range(0, 3) != 0);
            rin.addr  = 5'($urandom_range(0, 31));
            rin.wbsel = 2'($urandom_range(0, 3));
            rin.lt    = 3'($urandom_range(0, 7));
            rin.alu   = $urandom;
            rin.ld    = $urandom;
            rin.pc8   = $urandom;
            drive(rin);
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 7) == 0);
            @(posedge clk);
            #1;
            if (flush) begin
                m.valid = 1'b0;
                m.rw    = 1'b0;
                m.mis   = 1'b0;
            end else if (stall) begin
                m.mis = 1'b0;
            end else begin
                c      = ref_cap(rin);
                m      = c;
                m_addr = rin.addr;
                if (rin.valid) m_ir = m_ir + 32'd1;
            end
            chk1 ($sformatf("rnd%0d.rw", n),      RegWrite,    m.rw);
            chk1 ($sformatf("rnd%0d.valid", n),   wb_valid,    m.valid);
            chk1 ($sformatf("rnd%0d.mis", n),     wb_misalign, m.mis);
            chk32($sformatf("rnd%0d.data", n),    WriteData,   m.data);
            chk32($sformatf("rnd%0d.addr", n),    {27'd0, WriteAddr}, {27'd0, m_addr});
            chk32($sformatf("rnd%0d.instret", n), instret,     m_ir);
        end
        stall = 1'b0;
        flush = 1'b0;

        // Counter wraps silently from all-ones.
        @(negedge clk);
        drive(mk_in(0, 0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0));
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        chk32("wrap.preset", instret, 32'hFFFF_FFFF);
        @(negedge clk);
        drive(mk_in(1, 1, 5'd4, 2'd0, 3'd0, 32'h0000_0042, 32'd0));
        @(posedge clk);
        #1;
        chk32("wrap.instret", instret, 32'd0);

        // Asynchronous reset between edges discards the pending write.
        @(negedge clk);
        drive(mk_in(1, 1, 5'd5, 2'd0, 3'd0, 32'h12345678, 32'd0));
        @(posedge clk);
        #1;
        chk1("prerst.rw", RegWrite, 1'b1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk1 ("midrst.rw",      RegWrite,  1'b0);
        chk32("midrst.data",    WriteData, 32'd0);
        chk32("midrst.instret", instret,   32'd0);
        chk1 ("midrst.valid",   wb_valid,  1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(mk_in(1, 1, 5'd8, 2'd2, 3'd0, 32'd0, 32'd0));
        @(posedge clk);
        #1;
        chk1 ("first.valid",   wb_valid,  1'b1);
        chk32("first.data",    WriteData, 32'h0040_0010);
        chk32("first.instret", instret,   32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
